kbd_event_queue: RTL and testbench



---
 rtl/kbd_event_queue_if.sv | 27 ++
 rtl/kbd_event_queue.sv | 121 ++++++++++++
 tb/tb_kbd_event_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/kbd_event_queue_if.sv
// CPU-facing bus of the keyboard event queue: scancode input, pop/flush strobes,
// and the head-of-queue event with status.
interface kbd_event_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          CODE_VLD;
    logic [7:0]    CODE;
    logic          RD;
    logic          CLR;
    logic [9:0]    EVT_DATA;
    logic          EVT_VLD;
    logic [PW-1:0] COUNT;
    logic          OVF;
    logic          INTRPT;

    modport master (
        output CODE_VLD, CODE, RD, CLR,
        input  EVT_DATA, EVT_VLD, COUNT, OVF, INTRPT
    );

    modport slave (
        input  CODE_VLD, CODE, RD, CLR,
        output EVT_DATA, EVT_VLD, COUNT, OVF, INTRPT
    );
endinterface

// File: rtl/kbd_event_queue.sv
// PS/2 scancode sequencer (E0/F0 prefixes -> {EXT,REL,CODE} events) feeding a show-ahead FIFO.
// Optional KBD_BREAK_FILTER_EN: release events are parsed but never queued.
module kbd_event_queue #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    kbd_event_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BRK     = 2'b01,
        ST_EXT     = 2'b10,
        ST_EXT_BRK = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           tmo_q, tmo_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][9:0]   mem_q, mem_d;
    logic                    ovf_q, ovf_d;

    logic                    push_req, push_en, push_ok, pop_ok;
    logic [9:0]              push_data;
    logic                    full, empty;

    // Parser: the state encodes {ext,brk}, so the pending flags are the state bits.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        push_req  = 1'b0;
        push_data = 10'h000;
        if (bus.CODE_VLD) begin
            tmo_d = '0;
            case (bus.CODE)
                8'hE0:   state_d = (state_q == ST_BRK || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
                8'hF0:   state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
                default: begin
                    push_req  = 1'b1;
                    push_data = {state_q[1], state_q[0], bus.CODE};
                    state_d   = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
        end
        if (bus.CLR) begin
            state_d  = ST_IDLE;
            tmo_d    = '0;
            push_req = 1'b0;
        end
    end

`ifdef KBD_BREAK_FILTER_EN
    assign push_en = push_req & ~push_data[8];
`else
    assign push_en = push_req;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop while full frees the slot the coincident push lands in.
    assign pop_ok  = bus.RD & ~empty & ~bus.CLR;
    assign push_ok = push_en & (~full | bus.RD);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        ovf_d    = ovf_q;
        if (bus.CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_en && full && !bus.RD)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.EVT_DATA = empty ? 10'h000 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.EVT_VLD  = ~empty;
    assign bus.INTRPT   = ~empty;
    assign bus.COUNT    = wr_ptr_q - rd_ptr_q;
    assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue (DEPTH=8, short timeout); expectations follow
// KBD_BREAK_FILTER_EN when the bench is built with it.
module tb_kbd_event_queue;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic CLK;
    logic RST_N;
    int   tests = 0;
    int   fails = 0;

    kbd_event_queue_if #(.DEPTH(DEPTH)) bus ();

    kbd_event_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the falling edge too.
    task automatic send(input logic [7:0] b);
        bus.CODE_VLD = 1'b1;
        bus.CODE     = b;
        @(negedge CLK);
        bus.CODE_VLD = 1'b0;
        bus.CODE     = 8'h00;
    endtask

    task automatic pop();
        bus.RD = 1'b1;
        @(negedge CLK);
        bus.RD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        bus.CODE_VLD = 1'b0;
        bus.CODE     = 8'h00;
        bus.RD       = 1'b0;
        bus.CLR      = 1'b0;
        RST_N        = 1'b0;
        idle(2);
        chk("rst_data",  32'(bus.EVT_DATA), 32'h000);
        chk("rst_vld",   32'(bus.EVT_VLD),  32'h0);
        chk("rst_count", 32'(bus.COUNT),    32'h0);
        chk("rst_ovf",   32'(bus.OVF),      32'h0);
        chk("rst_int",   32'(bus.INTRPT),   32'h0);
        RST_N = 1'b1;
        idle(1);

        // make / break of the same key
        send(8'h1C); send(8'hF0); send(8'h1C);
`ifdef KBD_BREAK_FILTER_EN
        chk("mb_count", 32'(bus.COUNT),    32'd1);
        chk("mb_head",  32'(bus.EVT_DATA), 32'h01C);
        pop();
        chk("mb_empty", 32'(bus.EVT_DATA), 32'h000);
`else
        chk("mb_count", 32'(bus.COUNT),    32'd2);
        chk("mb_head",  32'(bus.EVT_DATA), 32'h01C);
        pop();
        chk("mb_head2", 32'(bus.EVT_DATA), 32'h11C);
        pop();
`endif
        chk("mb_drained", 32'(bus.COUNT), 32'd0);

        // extended make / break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_head", 32'(bus.EVT_DATA), 32'h275);
        chk("ext_int",  32'(bus.INTRPT),   32'h1);
        pop();
`ifndef KBD_BREAK_FILTER_EN
        chk("ext_head2", 32'(bus.EVT_DATA), 32'h375);
        chk("ext_int2",  32'(bus.INTRPT),   32'h1);
        pop();
`endif
        chk("ext_int_lo", 32'(bus.INTRPT),   32'h0);
        chk("ext_zero",   32'(bus.EVT_DATA), 32'h000);

        // pop while empty
        pop();
        chk("uf_count", 32'(bus.COUNT), 32'd0);
        chk("uf_vld",   32'(bus.EVT_VLD), 32'h0);

        // overflow: nine codes into eight slots
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i));
        chk("ovf_count", 32'(bus.COUNT),    32'd8);
        chk("ovf_flag",  32'(bus.OVF),      32'h1);
        chk("ovf_head",  32'(bus.EVT_DATA), 32'h001);
        pop();
        chk("ovf_pop",   32'(bus.EVT_DATA), 32'h002);
        chk("ovf_cnt7",  32'(bus.COUNT),    32'd7);
        chk("ovf_keep",  32'(bus.OVF),      32'h1);
        send(8'h0A);
        chk("refill",    32'(bus.COUNT),    32'd8);
        bus.RD = 1'b1;
        send(8'h0B);
        bus.RD = 1'b0;
        chk("pp_count",  32'(bus.COUNT),    32'd8);
        chk("pp_ovf",    32'(bus.OVF),      32'h1);
        chk("pp_head",   32'(bus.EVT_DATA), 32'h003);

        // CLR beats a coincident push
        bus.CLR = 1'b1;
        send(8'h0C);
        bus.CLR = 1'b0;
        chk("clr_count", 32'(bus.COUNT),   32'd0);
        chk("clr_ovf",   32'(bus.OVF),     32'h0);
        chk("clr_vld",   32'(bus.EVT_VLD), 32'h0);
        idle(1);
        chk("clr_nopush", 32'(bus.COUNT),  32'd0);

        // prefix timeout
        send(8'hE0);
        idle(TMO);
        send(8'h1C);
        chk("tmo_drop", 32'(bus.EVT_DATA), 32'h01C);
        pop();
        send(8'hE0);
        idle(TMO - 2);
        send(8'h1C);
        chk("tmo_keep", 32'(bus.EVT_DATA), 32'h21C);
        pop();
        chk("tmo_empty", 32'(bus.COUNT), 32'd0);

        // asynchronous reset between prefix and code
        send(8'h33);
        send(8'hE0);
        chk("ar_pre", 32'(bus.COUNT), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("ar_data",  32'(bus.EVT_DATA), 32'h000);
        chk("ar_count", 32'(bus.COUNT),    32'd0);
        chk("ar_int",   32'(bus.INTRPT),   32'h0);
        chk("ar_vld",   32'(bus.EVT_VLD),  32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(1);
        send(8'h75);
        chk("ar_post", 32'(bus.EVT_DATA), 32'h075);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
